// File: rtl/neuron_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_datapath_pkg
// Description : Shared widths, opcodes, instruction layout and fixed-point
//               helpers for the neuron arithmetic engine.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_datapath_pkg;

    localparam int DATA_WIDTH        = 16;
    localparam int FRAC_BITS         = 8;
    localparam int OPCODE_WIDTH      = 4;
    localparam int RESULT_WIDTH      = DATA_WIDTH;
    localparam int INSTRUCTION_WIDTH = OPCODE_WIDTH + 2 * DATA_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_ADD  = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_SUB  = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_MUL  = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_MAX  = 4'd3;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_RELU = 4'd4;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_SIG  = 4'd5;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_RAND = 4'd6;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Field order matches the instruction bus, MSB first.
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [DATA_WIDTH-1:0]   a;
        logic [DATA_WIDTH-1:0]   b;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

    localparam logic signed [2*DATA_WIDTH-1:0] SAT_MAX =
        {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [2*DATA_WIDTH-1:0] SAT_MIN =
        {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic signed [2*DATA_WIDTH-1:0] widen(input logic [DATA_WIDTH-1:0] v);
        return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [2*DATA_WIDTH-1:0] v);
        logic signed [2*DATA_WIDTH-1:0] w_clamped;
        if (v > SAT_MAX)
            w_clamped = SAT_MAX;
        else if (v < SAT_MIN)
            w_clamped = SAT_MIN;
        else
            w_clamped = v;
        return w_clamped[DATA_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_datapath_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : neuron_datapath_seq_multiplier
// Description : Signed shift-add multiplier, one multiplier bit per cycle,
//               WIDTH cycles per product. done marks the final cycle, during
//               which product already carries the complete result.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_datapath_seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic signed [WIDTH-1:0]   multiplicand,
    input  logic signed [WIDTH-1:0]   multiplier,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);

    localparam int                CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    logic                      r_busy;
    logic [CW-1:0]             r_count;
    logic signed [2*WIDTH-1:0] r_acc;
    logic signed [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]          r_mplier;
    logic signed [2*WIDTH-1:0] w_shifted;
    logic signed [2*WIDTH-1:0] w_partial;

    // The sign bit of a two's complement multiplier carries negative weight.
    always_comb begin
        w_shifted = r_mcand << r_count;
        w_partial = '0;
        if (r_mplier[r_count])
            w_partial = (r_count == LAST) ? -w_shifted : w_shifted;
    end

    assign product = r_acc + w_partial;
    assign done    = r_busy && (r_count == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (load) begin
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
            r_mplier <= multiplier;
        end else if (r_busy) begin
            r_acc   <= product;
            r_count <= r_count + 1'b1;
            if (done)
                r_busy <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_datapath.sv
`default_nettype none
// ============================================================================
// Module      : neuron_datapath
// Description : Fixed-point neuron arithmetic engine: one instruction per
//               start edge, one saturated result plus finished level.
//               Define DATAPATH_RAND_EN to add the LFSR-backed RAND opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_datapath
    import neuron_datapath_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic                         start,
    output logic [RESULT_WIDTH-1:0]      result,
    output logic                         finished
);

    localparam logic signed [DATA_WIDTH-1:0] SIG_HI     = DATA_WIDTH'(4 << FRAC_BITS);
    localparam logic signed [DATA_WIDTH-1:0] SIG_LO     = -SIG_HI;
    localparam logic [DATA_WIDTH-1:0]        FIXED_ONE  = DATA_WIDTH'(1 << FRAC_BITS);
    localparam logic signed [DATA_WIDTH-1:0] FIXED_HALF = DATA_WIDTH'(1 << (FRAC_BITS - 1));

    state_e                           r_state;
    state_e                           w_state_next;
    logic                             r_start_q;
    instr_t                           r_instr;
    logic [RESULT_WIDTH-1:0]          r_result;
    logic [RESULT_WIDTH-1:0]          w_result_next;
    logic                             w_accept;
    logic                             w_load_mul;
    logic                             w_mul_done;
    logic signed [DATA_WIDTH-1:0]     w_a;
    logic signed [DATA_WIDTH-1:0]     w_b;
    logic signed [2*DATA_WIDTH-1:0]   w_product;
    logic signed [2*DATA_WIDTH-1:0]   w_mul_scaled;
    logic [DATA_WIDTH-1:0]            w_alu;

    assign w_a      = r_instr.a;
    assign w_b      = r_instr.b;
    assign w_accept = start && !r_start_q && (r_state == ST_IDLE);
    assign result   = r_result;
    assign finished = (r_state == ST_IDLE);

`ifdef DATAPATH_RAND_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clock) begin
        if (reset)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
    end
`endif

    neuron_datapath_seq_multiplier #(
        .WIDTH        (DATA_WIDTH)
    ) u_mult (
        .clock        (clock),
        .reset        (reset),
        .load         (w_load_mul),
        .multiplicand (w_a),
        .multiplier   (w_b),
        .done         (w_mul_done),
        .product      (w_product)
    );

    // Arithmetic shift floors toward -inf before saturation.
    assign w_mul_scaled = w_product >>> FRAC_BITS;

    always_comb begin
        w_alu = '0;
        case (r_instr.opcode)
            OPCODE_ADD:  w_alu = saturate(widen(r_instr.a) + widen(r_instr.b));
            OPCODE_SUB:  w_alu = saturate(widen(r_instr.a) - widen(r_instr.b));
            OPCODE_MAX:  w_alu = (w_a > w_b) ? r_instr.a : r_instr.b;
            OPCODE_RELU: w_alu = w_a[DATA_WIDTH-1] ? '0 : r_instr.a;
            OPCODE_SIG: begin
                if (w_a <= SIG_LO)
                    w_alu = '0;
                else if (w_a >= SIG_HI)
                    w_alu = FIXED_ONE;
                else
                    w_alu = FIXED_HALF + (w_a >>> 3);
            end
`ifdef DATAPATH_RAND_EN
            OPCODE_RAND: w_alu = {{(DATA_WIDTH-FRAC_BITS){1'b0}}, r_lfsr[FRAC_BITS-1:0]};
`endif
            default:     w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        w_load_mul    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (r_instr.opcode == OPCODE_MUL) begin
                    w_state_next = ST_MUL;
                    w_load_mul   = 1'b1;
                end else begin
                    w_state_next  = ST_IDLE;
                    w_result_next = w_alu;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next  = ST_IDLE;
                    w_result_next = saturate(w_mul_scaled);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_instr   <= '0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_start_q <= start;
            r_result  <= w_result_next;
            if (w_accept)
                r_instr <= instruction;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_datapath
// Description : Self-checking bench for neuron_datapath: directed corner
//               cases plus randomized instructions against a numeric model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_datapath;

    logic        clock;
    logic        reset;
    logic [35:0] instruction;
    logic        start;
    logic [15:0] result;
    logic        finished;

    int n_vectors;
    int n_miscompares;

    neuron_datapath dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .start       (start),
        .result      (result),
        .finished    (finished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Numeric reference: real-valued fixed-point rules with floor and clamp.
    function automatic logic [15:0] ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        longint sa;
        longint sb;
        longint r;
        longint p;
        logic [15:0] out;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: r = sa + sb;
            4'd1: r = sa - sb;
            4'd2: begin
                p = sa * sb;
                r = p / 256;
                if (p < 0 && r * 256 != p) r = r - 1;
            end
            4'd3: r = (sa > sb) ? sa : sb;
            4'd4: r = (sa < 0) ? 0 : sa;
            4'd5: begin
                if (sa <= -1024)     r = 0;
                else if (sa >= 1024) r = 256;
                else begin
                    p = sa / 8;
                    if (sa < 0 && p * 8 != sa) p = p - 1;
                    r = 128 + p;
                end
            end
            default: r = 0;
        endcase
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        out = r[15:0];
        return out;
    endfunction

    // One transaction: fresh edge, optional long hold or mid-op start glitches.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold, input bit glitch, input bit use_model,
                         input string tag, output logic [15:0] got);
        int k;
        int held;
        int exp_lat;
        bit idle_ok;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        instruction = {op, a, b};
        start = 1'b1;
        @(posedge clock);
        #1;
        check_value({tag, "_busy"}, {31'd0, finished}, 32'd0);
        k = 0;
        held = 1;
        while (!finished && k < 40) begin
            if (glitch)
                start = (k >= 2 && k <= 10) ? k[0] : 1'b0;
            else
                start = (held < hold);
            @(posedge clock);
            #1;
            k++;
            held++;
        end
        exp_lat = (op == 4'd2) ? 17 : 1;
        check_value({tag, "_lat"}, k, exp_lat);
        got = result;
        if (use_model)
            check_value({tag, "_res"}, {16'd0, result}, {16'd0, ref_model(op, a, b)});
        idle_ok = 1'b1;
        while (held < hold) begin
            @(posedge clock);
            #1;
            held++;
            if (!finished || result !== got) idle_ok = 1'b0;
        end
        start = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (!finished || result !== got) idle_ok = 1'b0;
        end
        check_value({tag, "_hold"}, {31'd0, idle_ok}, 32'd1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        logic [15:0] r2;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          sel;
        bit          ok;
        n_vectors     = 0;
        n_miscompares = 0;
        reset         = 1'b1;
        start         = 1'b0;
        instruction   = '0;
        repeat (3) @(posedge clock);
        #1;
        check_value("rst_finished", {31'd0, finished}, 32'd1);
        check_value("rst_result", {16'd0, result}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        do_op(4'd0, 16'h0180, 16'h0080, 1, 0, 1, "add_basic", r);
        check_value("add_basic_val", {16'd0, r}, 32'h0200);
        do_op(4'd0, 16'h7F00, 16'h7F00, 1, 0, 1, "add_sat", r);
        check_value("add_sat_val", {16'd0, r}, 32'h7FFF);
        do_op(4'd1, 16'h8100, 16'h7F00, 1, 0, 1, "sub_sat", r);
        check_value("sub_sat_val", {16'd0, r}, 32'h8000);
        do_op(4'd2, 16'h0200, 16'hFF00, 1, 1, 1, "mul_glitch", r);
        check_value("mul_val", {16'd0, r}, 32'hFE00);
        do_op(4'd2, 16'h8000, 16'h8000, 1, 0, 1, "mul_sat", r);
        check_value("mul_sat_val", {16'd0, r}, 32'h7FFF);
        do_op(4'd5, 16'hFA00, 16'h0000, 1, 0, 1, "sig_lo", r);
        check_value("sig_lo_val", {16'd0, r}, 32'h0000);
        do_op(4'd5, 16'h0500, 16'h0000, 1, 0, 1, "sig_hi", r);
        check_value("sig_hi_val", {16'd0, r}, 32'h0100);
        do_op(4'd5, 16'h0100, 16'h0000, 1, 0, 1, "sig_mid", r);
        check_value("sig_mid_val", {16'd0, r}, 32'h00A0);
        do_op(4'd4, 16'hFF00, 16'h0000, 1, 0, 1, "relu_neg", r);
        check_value("relu_val", {16'd0, r}, 32'h0000);
        do_op(4'd3, 16'hFF00, 16'h0010, 1, 0, 1, "max", r);
        check_value("max_val", {16'd0, r}, 32'h0010);
        do_op(4'd0, 16'h0100, 16'h0100, 3, 0, 1, "start_hold3", r);
        check_value("hold3_val", {16'd0, r}, 32'h0200);
        do_op(4'd15, 16'h1234, 16'h5678, 1, 0, 1, "op15", r);
        check_value("op15_val", {16'd0, r}, 32'h0000);

`ifdef DATAPATH_RAND_EN
        do_op(4'd6, 16'h0000, 16'h0000, 1, 0, 0, "rand1", r);
        do_op(4'd6, 16'h0000, 16'h0000, 1, 0, 0, "rand2", r2);
        check_value("rand1_range", {31'd0, (r <= 16'h00FF)}, 32'd1);
        check_value("rand2_range", {31'd0, (r2 <= 16'h00FF)}, 32'd1);
        check_value("rand_differ", {31'd0, (r != r2)}, 32'd1);
`else
        do_op(4'd6, 16'h1111, 16'h2222, 1, 0, 1, "rand_off", r);
        check_value("rand_off_val", {16'd0, r}, 32'h0000);
`endif

        // Reset during a multiply must abort it with no later completion.
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        instruction = {4'd2, 16'h0300, 16'h0200};
        start = 1'b1;
        repeat (6) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        #1;
        check_value("rst_mul_finished", {31'd0, finished}, 32'd1);
        check_value("rst_mul_result", {16'd0, result}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ok = 1'b1;
        repeat (30) begin
            @(posedge clock);
            #1;
            if (!finished || result !== 16'h0000) ok = 1'b0;
        end
        check_value("rst_mul_no_stale", {31'd0, ok}, 32'd1);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 15);
            if (sel < 12) op = 4'(sel % 6);
            else          op = 4'($urandom_range(6, 15));
`ifdef DATAPATH_RAND_EN
            if (op == 4'd6) op = 4'd0;
`endif
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a = 16'($signed(12'($urandom)));
            if ($urandom_range(0, 1) == 1) b = 16'($signed(12'($urandom)));
            do_op(op, a, b, $urandom_range(1, 4), 0, 1, "rnd", r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
